fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002 SHALL have parameter INS_W, default 8, instruction word width.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >= 2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port stall  input  1  suppresses new fetches while high.
REQ-008 SHALL have port jmp_valid  input  1  absolute jump request.
REQ-009 SHALL have port jmp_target  input  PC_W  jump destination.
REQ-010 SHALL have port call_valid  input  1  call request.
REQ-011 SHALL have port call_target  input  PC_W  call destination.
REQ-012 SHALL have port ret_valid  input  1  return request.
REQ-013 SHALL have port imem_addr  output  PC_W  instruction-memory address, combinationally equal to the PC register.
REQ-014 SHALL have port imem_data  input  INS_W  instruction word, valid combinationally in the same cycle as imem_addr.
REQ-015 SHALL have port out_valid  output  1  out_pc/out_ins hold a fetched instruction.
REQ-016 SHALL have port out_ready  input  1  downstream accepts the instruction.
REQ-017 SHALL have port out_pc  output  PC_W  address of the presented instruction.
REQ-018 SHALL have port out_ins  output  INS_W  presented instruction word.
REQ-019 SHALL have port ras_count  output  $clog2(RAS_DEPTH)+1  number of valid stack entries.
REQ-020 SHALL have port ras_ovf  output  1  one-cycle pulse: push while stack full.
REQ-021 SHALL have port ras_unf  output  1  one-cycle pulse: pop while stack empty.

Function
REQ-022 SHALL define transfer = out_valid & out_ready, and fire = ~stall & (~out_valid | out_ready).
REQ-023 SHALL, on fire with no redirect, load out_pc<=pc, out_ins<=imem_data, out_valid<=1, pc<=pc+1 mod 2^PC_W (wrap from all-ones to 0).
REQ-024 SHALL, when not firing and no redirect, hold pc; clear out_valid on transfer, otherwise hold out_valid/out_pc/out_ins unchanged.
REQ-025 SHALL treat jmp_valid, call_valid and ret_valid as redirects with priority jmp > call > ret; lower-priority requests in the same cycle are ignored (no stack effect).
REQ-026 SHALL, on any redirect, set out_valid<=0 (flush), load pc with the new target and perform no fetch that cycle, regardless of stall/out_ready.
REQ-027 SHALL, on jmp, load pc<=jmp_target; stack unchanged.
REQ-028 SHALL, on call, push out_pc+1 (mod 2^PC_W) and load pc<=call_target.
REQ-029 SHALL, on call with ras_count==RAS_DEPTH, overwrite the oldest entry, keep ras_count at RAS_DEPTH and pulse ras_ovf.
REQ-030 SHALL, on ret with ras_count>0, load pc<=top entry and decrement ras_count.
REQ-031 SHALL, on ret with ras_count==0, load pc<=RESET_PC, keep ras_count 0 and pulse ras_unf.
REQ-032 SHALL give one-cycle fetch latency: an instruction at address A appears on out_* the cycle after pc==A fires, and a redirect target appears at the earliest one cycle after the redirect edge.
REQ-033 SHALL never change out_pc/out_ins while out_valid=1 and out_ready=0 (except flush by redirect).

Reset
REQ-034 SHALL, while reset=1, immediately force pc=RESET_PC, out_valid=0, out_pc=0, out_ins=0, ras_count=0, ras_ovf=0, ras_unf=0, independent of clk.
REQ-035 SHALL discard any in-flight instruction and stack contents on reset asserted mid-operation; first fetch after release at RESET_PC.

Verification
REQ-036 SHALL cover: reset release, stall=0, out_ready=1, imem_data=mem[addr] -> out_pc 0,1,2,... one per cycle, out_valid=1 from second edge; pc 255 wraps to 0 (PC_W=8).
REQ-037 SHALL cover: out_ready=0 for 3 cycles with out_pc=5 -> out_pc/out_ins held at 5, pc held at 6; out_ready=1 -> 6 presented next cycle.
REQ-038 SHALL cover: jmp_valid with jmp_target=0x40 and call_valid same cycle -> out_valid=0 next cycle, then out_pc=0x40, ras_count unchanged.
REQ-039 SHALL cover: call at out_pc=0x10 to 0x80, then ret -> ras_count 1 then 0, fetch resumes at 0x11.
REQ-040 SHALL cover: 5 calls with RAS_DEPTH=4 -> ras_ovf pulse on fifth, ras_count=4; 5 rets -> last 4 targets in LIFO order, fifth ret pulses ras_unf and pc=RESET_PC.
REQ-041 SHALL cover: reset asserted between clock edges while out_valid=1 -> out_valid=0 and pc=RESET_PC without waiting for clk.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-entry output register with valid/ready
// handshake, and a circular return-address stack for call/ret redirects.
module fetch_stage #(
    parameter int PC_W      = 8,
    parameter int INS_W     = 8,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           jmp_valid,
    input  logic [PC_W-1:0]                jmp_target,
    input  logic                           call_valid,
    input  logic [PC_W-1:0]                call_target,
    input  logic                           ret_valid,
    output logic [PC_W-1:0]                imem_addr,
    input  logic [INS_W-1:0]               imem_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PC_W-1:0]                out_pc,
    output logic [INS_W-1:0]               out_ins,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_ovf,
    output logic                           ras_unf
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] ras_mem [RAS_DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   wp_dec;
    logic            fire;
    logic            transfer;
    logic            push;
    logic            pop;
    logic            ras_full;
    logic            ras_empty;

    assign imem_addr = pc;
    assign transfer  = out_valid & out_ready;
    assign fire      = ~stall & (~out_valid | out_ready);
    assign push      = ~jmp_valid & call_valid;
    assign pop       = ~jmp_valid & ~call_valid & ret_valid;
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign ras_empty = (ras_count == '0);
    assign wp_dec    = wp - AW'(1);

    // wp is the next free slot; when full it already points at the oldest
    // entry, so a push naturally overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= PC_W'(RESET_PC);
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_ins   <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
            wp        <= '0;
        end else begin
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
            if (jmp_valid) begin
                pc        <= jmp_target;
                out_valid <= 1'b0;
            end else if (push) begin
                pc        <= call_target;
                out_valid <= 1'b0;
                wp        <= wp + AW'(1);
                if (ras_full) ras_ovf   <= 1'b1;
                else          ras_count <= ras_count + CW'(1);
            end else if (pop) begin
                out_valid <= 1'b0;
                if (ras_empty) begin
                    pc      <= PC_W'(RESET_PC);
                    ras_unf <= 1'b1;
                end else begin
                    pc        <= ras_mem[wp_dec];
                    wp        <= wp_dec;
                    ras_count <= ras_count - CW'(1);
                end
            end else if (fire) begin
                out_pc    <= pc;
                out_ins   <= imem_data;
                out_valid <= 1'b1;
                pc        <= pc + PC_W'(1);
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    // NOTE: stack storage has no reset; ras_count alone defines which entries are
    // live, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) ras_mem[wp] <= out_pc + PC_W'(1);
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, backpressure, redirect priority,
// PC wrap, call/ret with stack overflow/underflow, stall and asynchronous reset.
module tb_fetch_stage;
    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       jmp_valid;
    logic [7:0] jmp_target;
    logic       call_valid;
    logic [7:0] call_target;
    logic       ret_valid;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pc;
    logic [7:0] out_ins;
    logic [2:0] ras_count;
    logic       ras_ovf;
    logic       ras_unf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] ins_of(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    assign imem_data = ins_of(imem_addr);

    fetch_stage #(.PC_W(8), .INS_W(8), .RAS_DEPTH(4), .RESET_PC(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .call_valid (call_valid),
        .call_target(call_target),
        .ret_valid  (ret_valid),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_ins    (out_ins),
        .ras_count  (ras_count),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] pc_e, input logic [7:0] addr_e);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check({tag, ".out_pc"}, 32'(out_pc), 32'(pc_e));
            check({tag, ".out_ins"}, 32'(out_ins), 32'(ins_of(pc_e)));
        end
        check({tag, ".addr"}, 32'(imem_addr), 32'(addr_e));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; out_ready = 1'b1;
        jmp_valid = 1'b0; jmp_target = '0;
        call_valid = 1'b0; call_target = '0; ret_valid = 1'b0;
        #3;
        check("rst.addr", 32'(imem_addr), 32'h0);
        check("rst.valid", 32'(out_valid), 32'h0);
        check("rst.out_pc", 32'(out_pc), 32'h0);
        check("rst.out_ins", 32'(out_ins), 32'h0);
        check("rst.ras_count", 32'(ras_count), 32'h0);
        check("rst.ovf", 32'(ras_ovf), 32'h0);
        check("rst.unf", 32'(ras_unf), 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;

        // sequential fetch 0..5
        for (int i = 0; i < 6; i++) begin
            step();
            check_out($sformatf("seq%0d", i), 1'b1, 8'(i), 8'(i + 1));
        end

        // backpressure: hold 5 for three cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("hold%0d", i), 1'b1, 8'h05, 8'h06);
        end
        out_ready = 1'b1;
        step();
        check_out("release", 1'b1, 8'h06, 8'h07);

        // jmp beats call in the same cycle
        jmp_valid = 1'b1; jmp_target = 8'h40; call_valid = 1'b1; call_target = 8'h80;
        step();
        check_out("jmp.flush", 1'b0, 8'h00, 8'h40);
        check("jmp.ras_count", 32'(ras_count), 32'h0);
        jmp_valid = 1'b0; call_valid = 1'b0;
        step();
        check_out("jmp.fetch", 1'b1, 8'h40, 8'h41);
        check("jmp.ras_count2", 32'(ras_count), 32'h0);

        // PC wrap 0xFF -> 0x00
        jmp_valid = 1'b1; jmp_target = 8'hFE;
        step();
        jmp_valid = 1'b0;
        step();
        check_out("wrap.fe", 1'b1, 8'hFE, 8'hFF);
        step();
        check_out("wrap.ff", 1'b1, 8'hFF, 8'h00);
        step();
        check_out("wrap.00", 1'b1, 8'h00, 8'h01);

        // call at 0x10 to 0x80, then ret resumes at 0x11
        jmp_valid = 1'b1; jmp_target = 8'h10;
        step();
        jmp_valid = 1'b0;
        step();
        check_out("c1.at10", 1'b1, 8'h10, 8'h11);
        call_valid = 1'b1; call_target = 8'h80;
        step();
        check_out("c1.call", 1'b0, 8'h00, 8'h80);
        check("c1.ras_count", 32'(ras_count), 32'h1);
        call_valid = 1'b0;
        step();
        check_out("c1.at80", 1'b1, 8'h80, 8'h81);
        ret_valid = 1'b1;
        step();
        check_out("c1.ret", 1'b0, 8'h00, 8'h11);
        check("c1.ras_count0", 32'(ras_count), 32'h0);
        check("c1.unf", 32'(ras_unf), 32'h0);
        ret_valid = 1'b0;
        step();
        check_out("c1.at11", 1'b1, 8'h11, 8'h12);

        // five calls into a 4-deep stack; pushes 0x12,0x21,0x31,0x41,0x51
        for (int k = 0; k < 5; k++) begin
            call_valid = 1'b1; call_target = 8'(8'h20 + 8'h10 * k);
            step();
            check($sformatf("ovf.count%0d", k), 32'(ras_count), 32'((k < 4) ? k + 1 : 4));
            check($sformatf("ovf.pulse%0d", k), 32'(ras_ovf), 32'((k == 4) ? 1 : 0));
            call_valid = 1'b0;
            step();
            check_out($sformatf("ovf.fetch%0d", k), 1'b1, 8'(8'h20 + 8'h10 * k), 8'(8'h21 + 8'h10 * k));
            check($sformatf("ovf.clear%0d", k), 32'(ras_ovf), 32'h0);
        end

        // five rets: LIFO 0x51,0x41,0x31,0x21, then underflow to RESET_PC
        ret_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("ret.addr%0d", k), 32'(imem_addr), 32'(8'h51 - 8'h10 * k));
            check($sformatf("ret.count%0d", k), 32'(ras_count), 32'(3 - k));
            check($sformatf("ret.unf%0d", k), 32'(ras_unf), 32'h0);
        end
        step();
        check("unf.addr", 32'(imem_addr), 32'h0);
        check("unf.count", 32'(ras_count), 32'h0);
        check("unf.pulse", 32'(ras_unf), 32'h1);
        ret_valid = 1'b0;
        step();
        check("unf.clear", 32'(ras_unf), 32'h0);
        check_out("unf.fetch", 1'b1, 8'h00, 8'h01);

        // async reset mid-cycle with a stack entry live
        call_valid = 1'b1; call_target = 8'h30;
        step();
        call_valid = 1'b0;
        step();
        check_out("ar.pre", 1'b1, 8'h30, 8'h31);
        check("ar.pre_count", 32'(ras_count), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("ar.valid", 32'(out_valid), 32'h0);
        check("ar.addr", 32'(imem_addr), 32'h0);
        check("ar.out_pc", 32'(out_pc), 32'h0);
        check("ar.count", 32'(ras_count), 32'h0);
        #1 reset = 1'b0;
        step();
        check_out("ar.first", 1'b1, 8'h00, 8'h01);
        ret_valid = 1'b1;
        step();
        check("ar.ret_unf", 32'(ras_unf), 32'h1);
        check("ar.ret_addr", 32'(imem_addr), 32'h0);
        ret_valid = 1'b0;
        step();
        check_out("ar.refetch", 1'b1, 8'h00, 8'h01);

        // stall: presented word drains, pc holds
        stall = 1'b1;
        step();
        check_out("stall0", 1'b0, 8'h00, 8'h01);
        step();
        check_out("stall1", 1'b0, 8'h00, 8'h01);
        stall = 1'b0;
        step();
        check_out("unstall", 1'b1, 8'h01, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
